// File: rtl/branch_pkg.sv
// Shared branch encodings, flag positions and controller state type
// for the fetch/decode branch path.
package branch_pkg;

    localparam logic [1:0] BR_NONE   = 2'b00;
    localparam logic [1:0] BR_Z      = 2'b01;
    localparam logic [1:0] BR_NZ     = 2'b10;
    localparam logic [1:0] BR_ALWAYS = 2'b11;

    localparam int FLAG_Z  = 2;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: decides take from branch code and flags.
// Same decode table as the rest of the branch logic.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [1:0] branch,
    input  logic [2:0] flags,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        unique case (1'b1)
            (branch == BR_NONE):   take = 1'b0;
            (branch == BR_Z):      take = flags[FLAG_Z];
            (branch == BR_NZ):     take = ~flags[FLAG_Z];
            (branch == BR_ALWAYS): take = 1'b1;
            default:               take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_controller.sv
// Fetch PC sequencer: waits for owed ALU flags, resolves conditional
// branches, redirects the PC and flushes the wrong-path fetch.
module branch_pc_controller
    import branch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [1:0]        branch,
    input  logic [ADDR_W-1:0] target,
    input  logic              set_flags,
    input  logic [2:0]        flags,
    input  logic              flags_valid,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_valid,
    output logic              stall,
    output logic              flush,
    output logic              taken,
    output logic [CNT_W-1:0]  taken_count,
    output logic              timeout_err
);

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [3:0]        wait_cnt, wait_d;
    logic [2:0]        flags_q, eff_flags;
    logic              pending;
    logic              take, do_take, to_err, stall_c;
    logic              br_cond, br_any;

    assign eff_flags = flags_valid ? flags : flags_q;
    assign br_cond   = instr_valid && (branch == BR_Z || branch == BR_NZ);
    assign br_any    = instr_valid && (branch != BR_NONE);

    branch_cond_eval u_eval (
        .branch (branch),
        .flags  (eff_flags),
        .take   (take)
    );

    always_comb begin
        state_d = state;
        pc_d    = pc;
        wait_d  = wait_cnt;
        stall_c = 1'b0;
        do_take = 1'b0;
        to_err  = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (br_cond && pending && !flags_valid) begin
                    stall_c = 1'b1;
                    state_d = ST_WAIT;
                end else if (instr_valid && take) begin
                    do_take = 1'b1;
                    pc_d    = target;
                end else if (halt && !br_any) begin
                    state_d = ST_HALTED;
                end else begin
                    pc_d = pc + ADDR_W'(PC_STEP);
                end
            end
            ST_WAIT: begin
                if (flags_valid) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                    if (take) begin
                        do_take = 1'b1;
                        pc_d    = target;
                    end else begin
                        pc_d = pc + ADDR_W'(PC_STEP);
                    end
                end else if (wait_cnt == 4'(MAX_WAIT)) begin
                    // flags never came: give up, fall through not-taken
                    to_err  = 1'b1;
                    state_d = ST_RUN;
                    wait_d  = '0;
                    pc_d    = pc + ADDR_W'(PC_STEP);
                end else begin
                    stall_c = 1'b1;
                    wait_d  = wait_cnt + 4'd1;
                end
            end
            ST_HALTED: ;
            default: state_d = ST_RUN;
        endcase
    end

    assign stall       = stall_c && !reset;
    assign fetch_valid = !reset && (state != ST_HALTED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            wait_cnt    <= '0;
            flags_q     <= '0;
            pending     <= 1'b0;
            flush       <= 1'b0;
            taken       <= 1'b0;
            taken_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            wait_cnt <= wait_d;
            flush    <= do_take;
            taken    <= do_take;
            if (do_take && taken_count != {CNT_W{1'b1}})
                taken_count <= taken_count + 1'b1;
            if (to_err)
                timeout_err <= 1'b1;
            if (flags_valid)
                flags_q <= flags;
            // a new producer wins over a same-cycle flag return
            if (instr_valid && set_flags && !stall_c)
                pending <= 1'b1;
            else if (flags_valid)
                pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_pc_controller.sv
// Scoreboard bench for branch_pc_controller: directed cycles push
// expected outputs, a negedge monitor pops and compares.
module tb_branch_pc_controller;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [1:0]  branch = BR_NONE;
    logic [31:0] target = '0;
    logic        set_flags = 1'b0;
    logic [2:0]  flags = '0;
    logic        flags_valid = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic        fetch_valid, stall, flush, taken, timeout_err;
    logic [15:0] taken_count;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        fv, st, fl, tk, terr;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc_no  = 0;

    branch_pc_controller dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .branch      (branch),
        .target      (target),
        .set_flags   (set_flags),
        .flags       (flags),
        .flags_valid (flags_valid),
        .halt        (halt),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .stall       (stall),
        .flush       (flush),
        .taken       (taken),
        .taken_count (taken_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc", e.cyc, pc, e.pc);
            chk("fetch_valid", e.cyc, 32'(fetch_valid), 32'(e.fv));
            chk("stall", e.cyc, 32'(stall), 32'(e.st));
            chk("flush", e.cyc, 32'(flush), 32'(e.fl));
            chk("taken", e.cyc, 32'(taken), 32'(e.tk));
            chk("taken_count", e.cyc, 32'(taken_count), 32'(e.cnt));
            chk("timeout_err", e.cyc, 32'(timeout_err), 32'(e.terr));
        end
    end

    task automatic cyc(input logic r, iv, input logic [1:0] br,
                       input logic [31:0] tg, input logic sf, fvi,
                       input logic [2:0] fl, input logic h,
                       input logic [31:0] epc, input logic efv, est,
                       input logic efl, etk, input logic [15:0] ecnt,
                       input logic eterr);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; instr_valid = iv; branch = br; target = tg;
        set_flags = sf; flags_valid = fvi; flags = fl; halt = h;
        e.cyc = cyc_no; e.pc = epc; e.fv = efv; e.st = est;
        e.fl = efl; e.tk = etk; e.cnt = ecnt; e.terr = eterr;
        sb.push_back(e);
        cyc_no++;
    endtask

    initial begin
        // reset, idle fetch 0,4,8,12,0x10
        cyc(1,0,BR_NONE,0,0,0,0,0, 32'h00,0,0,0,0,0,0);
        cyc(0,0,BR_NONE,0,0,0,0,0, 32'h00,1,0,0,0,0,0);
        cyc(0,0,BR_NONE,0,0,0,0,0, 32'h04,1,0,0,0,0,0);
        cyc(0,0,BR_NONE,0,0,0,0,0, 32'h08,1,0,0,0,0,0);
        cyc(0,0,BR_NONE,0,0,0,0,0, 32'h0C,1,0,0,0,0,0);
        // unconditional at 0x10
        cyc(0,1,BR_ALWAYS,32'h40,0,0,0,0, 32'h10,1,0,0,0,0,0);
        cyc(0,0,BR_NONE,0,0,0,0,0, 32'h40,1,0,1,1,1,0);
        // producer, then BR_Z waits two cycles, Z=1 -> taken
        cyc(0,1,BR_NONE,0,1,0,0,0, 32'h44,1,0,0,0,1,0);
        cyc(0,1,BR_Z,32'h80,0,0,0,0, 32'h48,1,1,0,0,1,0);
        cyc(0,1,BR_Z,32'h80,0,0,0,0, 32'h48,1,1,0,0,1,0);
        cyc(0,1,BR_Z,32'h80,0,1,3'b100,0, 32'h48,1,0,0,0,1,0);
        // same with Z=0 -> fall through
        cyc(0,1,BR_NONE,0,1,0,0,0, 32'h80,1,0,1,1,2,0);
        cyc(0,1,BR_Z,32'hC0,0,0,0,0, 32'h84,1,1,0,0,2,0);
        cyc(0,1,BR_Z,32'hC0,0,0,0,0, 32'h84,1,1,0,0,2,0);
        cyc(0,1,BR_Z,32'hC0,0,1,3'b000,0, 32'h84,1,0,0,0,2,0);
        // BR_NZ with flags arriving same cycle: bypass, no stall
        cyc(0,1,BR_NONE,0,1,0,0,0, 32'h88,1,0,0,0,2,0);
        cyc(0,1,BR_NZ,32'h100,0,1,3'b000,0, 32'h8C,1,0,0,0,2,0);
        // timeout after 16 WAIT cycles
        cyc(0,1,BR_NONE,0,1,0,0,0, 32'h100,1,0,1,1,3,0);
        cyc(0,1,BR_Z,32'h200,0,0,0,0, 32'h104,1,1,0,0,3,0);
        for (int i = 0; i < 15; i++)
            cyc(0,1,BR_Z,32'h200,0,0,0,0, 32'h104,1,1,0,0,3,0);
        cyc(0,1,BR_Z,32'h200,0,0,0,0, 32'h104,1,0,0,0,3,0);
        cyc(0,0,BR_NONE,0,0,0,0,0, 32'h108,1,0,0,0,3,1);
        // halt held through WAIT, honoured after resolve
        cyc(0,1,BR_Z,32'h300,0,0,0,1, 32'h10C,1,1,0,0,3,1);
        cyc(0,1,BR_Z,32'h300,0,0,0,1, 32'h10C,1,1,0,0,3,1);
        cyc(0,1,BR_Z,32'h300,0,1,3'b100,1, 32'h10C,1,0,0,0,3,1);
        cyc(0,0,BR_NONE,0,0,0,0,1, 32'h300,1,0,1,1,4,1);
        cyc(0,0,BR_NONE,0,0,0,0,1, 32'h300,0,0,0,0,4,1);
        cyc(0,0,BR_NONE,0,0,0,0,0, 32'h300,0,0,0,0,4,1);
        // reset out of HALTED, then reset in WAIT
        cyc(1,0,BR_NONE,0,0,0,0,0, 32'h300,0,0,0,0,4,1);
        cyc(0,1,BR_NONE,0,1,0,0,0, 32'h00,1,0,0,0,0,0);
        cyc(0,1,BR_Z,32'h400,0,0,0,0, 32'h04,1,1,0,0,0,0);
        cyc(1,1,BR_Z,32'h400,0,0,0,0, 32'h04,0,0,0,0,0,0);
        cyc(0,0,BR_NONE,0,0,0,0,0, 32'h00,1,0,0,0,0,0);
        // pending cleared by reset: BR_Z resolves at once, Z=0
        cyc(0,1,BR_Z,32'h500,0,0,0,0, 32'h04,1,0,0,0,0,0);
        cyc(0,0,BR_NONE,0,0,0,0,0, 32'h08,1,0,0,0,0,0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", cyc_no, 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
